stp_frame_rcv: RTL

Framed serial-to-parallel receiver that consumes the 1-bit serial stream produced by the 4-bit parallel-to-serial stage. It detects a start bit, shifts in NUM_BITS data bits on each bit strobe, checks the stop bit, and presents the recovered word with a ready/acknowledge flag plus framing and overrun error flags. It sits directly downstream of the PTS shifter in the lab serial link, sharing its clock, reset and bit strobe.

---
 rtl/stp_frame_rcv_if.sv | 25 ++
 rtl/stp_frame_rcv.sv | 95 +++++++++
 2 files changed

// File: rtl/stp_frame_rcv_if.sv
// Bus between the serial line driver / word consumer and the frame receiver.
// The receiver connects through the slave modport. The driver connects through the master modport.
interface stp_frame_rcv_if #(
  parameter int NUM_BITS = 4
);
  logic                serial_in;
  logic                shift_enable;
  logic                data_read;
  logic [NUM_BITS-1:0] rx_data;
  logic                data_ready;
  logic                framing_error;
  logic                overrun_error;
  logic                busy;
  logic [1:0]          state_dbg;

  modport master (
    output serial_in, shift_enable, data_read,
    input  rx_data, data_ready, framing_error, overrun_error, busy, state_dbg
  );

  modport slave (
    input  serial_in, shift_enable, data_read,
    output rx_data, data_ready, framing_error, overrun_error, busy, state_dbg
  );
endinterface

// File: rtl/stp_frame_rcv.sv
// Framed serial-to-parallel receiver: start bit, NUM_BITS data bits and a stop bit, one bit per strobe.
// Valid/ready semantics: data_ready rises when a good word is loaded, and data_read acknowledges that word.
module stp_frame_rcv #(
  parameter int NUM_BITS  = 4,
  parameter bit MSB_FIRST = 1'b1
) (
  input  logic clk,
  input  logic n_rst,
  stp_frame_rcv_if.slave rx
);
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    DATA = 2'd1,
    STOP = 2'd2
  } state_t;

  localparam int CW = $clog2(NUM_BITS + 1);
  localparam logic [CW-1:0] LAST_BIT = CW'(NUM_BITS - 1);

  state_t              state_q;
  logic [CW-1:0]       cnt_q;
  logic [NUM_BITS-1:0] sr_q;
  logic [NUM_BITS-1:0] sr_d;
  logic [NUM_BITS-1:0] rx_data_q;
  logic                data_ready_q;
  logic                framing_error_q;
  logic                overrun_error_q;
  logic                busy_q;
  logic                good_load;

  always_comb begin
    sr_d = sr_q;
    if (MSB_FIRST) sr_d = {sr_q[NUM_BITS-2:0], rx.serial_in};
    else           sr_d = {rx.serial_in, sr_q[NUM_BITS-1:1]};
  end

  assign good_load = rx.shift_enable && (state_q == STOP) && rx.serial_in;

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state_q         <= IDLE;
      cnt_q           <= '0;
      sr_q            <= '0;
      rx_data_q       <= '0;
      data_ready_q    <= 1'b0;
      framing_error_q <= 1'b0;
      overrun_error_q <= 1'b0;
      busy_q          <= 1'b0;
    end else begin
      if (rx.shift_enable) begin
        case (state_q)
          IDLE: begin
            if (!rx.serial_in) begin
              state_q         <= DATA;
              cnt_q           <= '0;
              framing_error_q <= 1'b0;
              busy_q          <= 1'b1;
            end
          end
          DATA: begin
            sr_q  <= sr_d;
            cnt_q <= cnt_q + 1'b1;
            if (cnt_q == LAST_BIT) state_q <= STOP;
          end
          STOP: begin
            state_q <= IDLE;
            busy_q  <= 1'b0;
            if (rx.serial_in) rx_data_q       <= sr_q;
            else              framing_error_q <= 1'b1;
          end
          default: begin
            state_q <= IDLE;
            busy_q  <= 1'b0;
          end
        endcase
      end

      // An acknowledge on the load edge consumes the old word, so it cannot overrun.
      if (good_load) begin
        data_ready_q    <= 1'b1;
        overrun_error_q <= data_ready_q && !rx.data_read;
      end else if (rx.data_read) begin
        data_ready_q    <= 1'b0;
        overrun_error_q <= 1'b0;
      end
    end
  end

  assign rx.rx_data       = rx_data_q;
  assign rx.data_ready    = data_ready_q;
  assign rx.framing_error = framing_error_q;
  assign rx.overrun_error = overrun_error_q;
  assign rx.busy          = busy_q;
  assign rx.state_dbg     = state_q;
endmodule
